// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned press/start outputs of the button conditioner.
// The bench drives through `master`; the conditioner attaches to `slave`.
interface button_conditioner_if;
  logic [3:0] btn_raw;
  logic       start_raw;
  logic [3:0] player_input;
  logic       press_valid;
  logic       multi_press;
  logic       start_button;
  logic       start_pulse;
  logic [1:0] dbg_state;

  modport master (
    output btn_raw, start_raw,
    input  player_input, press_valid, multi_press, start_button, start_pulse, dbg_state
  );

  modport slave (
    input  btn_raw, start_raw,
    output player_input, press_valid, multi_press, start_button, start_pulse, dbg_state
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces four color buttons and a start button, then
// arbitrates color presses into one-hot single-cycle pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = 21
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    READY        = 2'd1,
    HELD         = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0] w_raw;
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] w_stable;
  logic [4:0] r_stable_d;
  logic [4:0] w_rise;
  logic [1:0] r_fill;
  logic       r_booted;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] w_color;
  logic [3:0] w_color_rise;
  logic       w_onehot;
  logic       w_leave_wait;
  logic [3:0] w_pi_next;
  logic       w_pv_next;
  logic       w_mp_next;

  logic [3:0] r_player_input;
  logic       r_press_valid;
  logic       r_multi_press;
  logic       r_start_pulse;

  assign w_raw = {bus.start_raw, bus.btn_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_fill  <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
    end
  end

  // Channel 4 is start; channels 0..3 are the colors.
  for (genvar g = 0; g < 5; g++) begin : g_deb
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (r_sync2[g] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt    <= '0;
        r_stable <= ~r_stable;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_stable[g] = r_stable;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stable_d <= '0;
    else        r_stable_d <= w_stable;
  end

  assign w_rise       = w_stable & ~r_stable_d;
  assign w_color      = w_stable[3:0];
  assign w_color_rise = w_rise[3:0];
  assign w_onehot     = (w_color != 4'd0) && ((w_color & (w_color - 4'd1)) == 4'd0);

  // Straight after reset every stable value reads 0 even if a button is held,
  // so the first exit from WAIT_RELEASE also waits for the synchronizers to
  // fill and show no color high.
  assign w_leave_wait = (w_color == 4'd0) &&
                        (r_booted || ((r_fill == 2'b11) && (r_sync2[3:0] == 4'd0)));

  always_comb begin
    w_state_next = r_state;
    w_pi_next    = 4'd0;
    w_pv_next    = 1'b0;
    w_mp_next    = 1'b0;
    case (r_state)
      WAIT_RELEASE: begin
        if (w_leave_wait) w_state_next = READY;
      end
      READY: begin
        if (w_color_rise != 4'd0) begin
          if (w_onehot) begin
            w_pi_next    = w_color;
            w_pv_next    = 1'b1;
            w_state_next = HELD;
          end else begin
            w_mp_next    = 1'b1;
            w_state_next = WAIT_RELEASE;
          end
        end
      end
      HELD: begin
        if (w_color == 4'd0) w_state_next = READY;
      end
      default: w_state_next = WAIT_RELEASE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= WAIT_RELEASE;
      r_booted       <= 1'b0;
      r_player_input <= '0;
      r_press_valid  <= 1'b0;
      r_multi_press  <= 1'b0;
      r_start_pulse  <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_booted       <= r_booted | (w_state_next == READY);
      r_player_input <= w_pi_next;
      r_press_valid  <= w_pv_next;
      r_multi_press  <= w_mp_next;
      r_start_pulse  <= w_rise[4];
    end
  end

  assign bus.player_input = r_player_input;
  assign bus.press_valid  = r_press_valid;
  assign bus.multi_press  = r_multi_press;
  assign bus.start_button = w_stable[4];
  assign bus.start_pulse  = r_start_pulse;
  assign bus.dbg_state    = r_state;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The module SHALL take parameter DEBOUNCE_CYCLES, default 2_000_000 (10 ms at 200 MHz), which is the number of consecutive cycles an input must differ from its stable value before the change is accepted; legal range is 2 or more.
REQ-002 The module SHALL take parameter CNT_W, default 21, which is the width of each debounce counter; it SHALL satisfy 2**CNT_W >= DEBOUNCE_CYCLES.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn_raw  input  4  asynchronous raw color buttons, bit0..bit3, active-high.
REQ-006 start_raw  input  1  asynchronous raw start button, active-high.
REQ-007 player_input  output  4  one-hot color press, asserted as a single-cycle pulse.
REQ-008 press_valid  output  1  single-cycle pulse, coincident with a non-zero player_input.
REQ-009 multi_press  output  1  single-cycle pulse flagging a rejected simultaneous press.
REQ-010 start_button  output  1  debounced start level.
REQ-011 start_pulse  output  1  single-cycle pulse on a start rising edge.

Function
REQ-012 Each of the 5 inputs SHALL pass through an independent 2-FF synchronizer before any other use.
REQ-013 Per channel debounce: the counter SHALL clear whenever the synchronized value equals the stable value.
REQ-014 Per channel debounce: the counter SHALL increment while the synchronized value differs from the stable value.
REQ-015 When the counter equals DEBOUNCE_CYCLES-1 and the inputs still differ, the stable value SHALL toggle on the next edge and the counter SHALL clear.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never change the stable value.
REQ-017 Latency: for a raw input held constant from edge t, its stable value SHALL change at edge t+2+DEBOUNCE_CYCLES and the registered output pulse SHALL appear at edge t+3+DEBOUNCE_CYCLES.
REQ-018 All outputs SHALL be registered.
REQ-019 The start channel is independent of the color channels.
REQ-020 start_button SHALL equal the registered stable start value.
REQ-021 start_pulse SHALL assert for exactly one cycle on each stable 0->1 transition of start.
REQ-022 Color arbitration SHALL be a FSM with states WAIT_RELEASE, READY and HELD, and reset state WAIT_RELEASE.
REQ-023 In WAIT_RELEASE, the FSM SHALL move to READY when all 4 stable color values are 0; no pulses are emitted in this state.
REQ-024 In READY, on any stable color rising edge, if exactly one stable color bit is 1: player_input SHALL equal that one-hot value and press_valid SHALL be 1 for one cycle, and the FSM SHALL go to HELD.
REQ-025 In READY, on any stable color rising edge, if two or more stable color bits are 1: multi_press SHALL be 1 for one cycle, player_input SHALL stay 0, and the FSM SHALL go to WAIT_RELEASE.
REQ-026 In HELD, any additional stable color rising edge SHALL be ignored, with no pulse and no error.
REQ-027 The FSM SHALL leave HELD for READY when all stable color bits are 0.
REQ-028 player_input SHALL be 4'b0000 in every cycle that press_valid is 0.
REQ-029 press_valid and multi_press SHALL never both be 1 in the same cycle.
REQ-030 Each debounce counter SHALL saturate logic at DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-031 While rst_n=0, all synchronizer flops, stable values, counters and outputs SHALL be 0 and the FSM SHALL be in WAIT_RELEASE.
REQ-032 Reset asserted mid-debounce or mid-press SHALL discard all progress.
REQ-033 After reset release, a button already held SHALL be debounced to stable 1 and SHALL cause WAIT_RELEASE to hold, with no press pulse until that button is released and pressed again.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 Single press: btn_raw 0000->0100 held 20 cycles -> exactly one cycle of player_input=0100 with press_valid=1, 7 edges after the change; release emits nothing.
REQ-035 Glitch: btn_raw bit1 high for 3 cycles, then low -> no pulses and no stable change.
REQ-036 Simultaneous press: btn_raw 0000->0011 in one cycle -> one multi_press pulse and player_input stays 0000; then release all, press 1000 -> player_input=1000 pulse.
REQ-037 Overlap: press 0001, then add 0010 while 0001 is still held -> only the 0001 pulse; no second pulse and no multi_press; release all and press 0010 -> 0010 pulse.
REQ-038 Start: start_raw 0->1 held -> start_button=1 and one start_pulse at edge t+7; a bounce 1-0-1 within 3 cycles -> no extra start_pulse.
REQ-039 Reset mid-operation: assert rst_n=0 during a counting press -> all outputs 0; release reset with the button held -> no pulse until the button is released and re-pressed.
